// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM for the accumulator CPU: fetch/decode/memrd/exec/memwr with
// memory handshake, halt-at-boundary and a memory-timeout watchdog. Optional macro: SEQ_ILLEGAL_TRAP_EN.
module multicycle_sequencer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] opr,
    input  logic       zero,
    input  logic       mem_ready,
    input  logic       halt_req,
    output logic       mem_read,
    output logic       mem_write,
    output logic       addr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_src,
    output logic       acc_write,
    output logic       acc_src,
    output logic [2:0] alu_cont,
    output logic       halted,
    output logic       fault,
    output logic [2:0] state
);

    // state | meaning
    // FETCH  | read instruction at PC, load IR, PC+1
    // DECODE | latch opcode, resolve jumps, pick next phase
    // MEMRD  | read operand at IR address
    // EXEC   | ALU result into ACC
    // MEMWR  | store ACC at IR address
    // HALTED | stopped by request, HLT or fault
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_MEMRD  = 3'd2,
        S_EXEC   = 3'd3,
        S_MEMWR  = 3'd4,
        S_HALTED = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE  = 2'd0,
        CAUSE_REQ   = 2'd1,
        CAUSE_HLT   = 2'd2,
        CAUSE_FAULT = 2'd3
    } cause_t;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_NOT = 4'b0100;
    localparam logic [3:0] OP_JMP = 4'b0110;
    localparam logic [3:0] OP_JZ  = 4'b0111;
    localparam logic [3:0] OP_LDA = 4'b1000;
    localparam logic [3:0] OP_STA = 4'b1001;
    localparam logic [3:0] OP_HLT = 4'b1111;

    // Timeout fires on the low cycle that would bring the counter up to MEM_TIMEOUT.
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_t           state_q, state_d;
    cause_t           cause_q, cause_d;
    logic [3:0]       op_q, op_d;
    logic [CNT_W-1:0] wait_q, wait_d;
    logic             fault_q, fault_d;
    logic             timeout_hit;
    logic             is_req;
    logic             finish;

    assign timeout_hit = (wait_q == WAIT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            cause_q <= CAUSE_NONE;
            op_q    <= 4'b0000;
            wait_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            op_q    <= op_d;
            wait_q  <= wait_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cause_d   = cause_q;
        op_d      = op_q;
        fault_d   = fault_q;
        is_req    = 1'b0;
        finish    = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        addr_src  = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_src    = 1'b0;
        acc_write = 1'b0;
        acc_src   = 1'b0;
        alu_cont  = 3'b000;
        halted    = 1'b0;

        case (state_q)
            S_FETCH: begin
                is_req   = 1'b1;
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (timeout_hit) begin
                    fault_d = 1'b1;
                    cause_d = CAUSE_FAULT;
                    state_d = S_HALTED;
                end
            end
            S_DECODE: begin
                op_d = opr;
                case (opr)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_LDA: state_d = S_MEMRD;
                    OP_NOT: state_d = S_EXEC;
                    OP_STA: state_d = S_MEMWR;
                    OP_JMP: begin
                        pc_write = 1'b1;
                        pc_src   = 1'b1;
                        finish   = 1'b1;
                    end
                    OP_JZ: begin
                        pc_write = zero;
                        pc_src   = 1'b1;
                        finish   = 1'b1;
                    end
                    OP_HLT: begin
                        state_d = S_HALTED;
                        cause_d = CAUSE_HLT;
                    end
                    default: begin
`ifdef SEQ_ILLEGAL_TRAP_EN
                        fault_d = 1'b1;
                        cause_d = CAUSE_FAULT;
                        state_d = S_HALTED;
`else
                        finish = 1'b1;
`endif
                    end
                endcase
            end
            S_MEMRD: begin
                is_req   = 1'b1;
                mem_read = 1'b1;
                addr_src = 1'b1;
                if (mem_ready) begin
                    if (op_q == OP_LDA) begin
                        acc_write = 1'b1;
                        acc_src   = 1'b1;
                        finish    = 1'b1;
                    end else begin
                        state_d = S_EXEC;
                    end
                end else if (timeout_hit) begin
                    fault_d = 1'b1;
                    cause_d = CAUSE_FAULT;
                    state_d = S_HALTED;
                end
            end
            S_EXEC: begin
                acc_write = 1'b1;
                case (op_q)
                    OP_SUB:  alu_cont = 3'b001;
                    OP_AND:  alu_cont = 3'b010;
                    OP_OR:   alu_cont = 3'b011;
                    OP_NOT:  alu_cont = 3'b100;
                    default: alu_cont = 3'b000;
                endcase
                finish = 1'b1;
            end
            S_MEMWR: begin
                is_req    = 1'b1;
                mem_write = 1'b1;
                addr_src  = 1'b1;
                if (mem_ready) begin
                    finish = 1'b1;
                end else if (timeout_hit) begin
                    fault_d = 1'b1;
                    cause_d = CAUSE_FAULT;
                    state_d = S_HALTED;
                end
            end
            S_HALTED: begin
                halted = 1'b1;
                if (cause_q == CAUSE_REQ && !halt_req) begin
                    state_d = S_FETCH;
                    cause_d = CAUSE_NONE;
                end
            end
            default: state_d = S_FETCH;
        endcase

        // Instruction boundary: the only point where an external halt is honoured.
        if (finish) begin
            if (halt_req) begin
                state_d = S_HALTED;
                cause_d = CAUSE_REQ;
            end else begin
                state_d = S_FETCH;
            end
        end

        if (state_d != state_q) begin
            wait_d = '0;
        end else if (is_req && !mem_ready) begin
            wait_d = wait_q + 1'b1;
        end else begin
            wait_d = wait_q;
        end

        // Hold every strobe low while reset is asserted.
        if (rst) begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
            addr_src  = 1'b0;
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            pc_src    = 1'b0;
            acc_write = 1'b0;
            acc_src   = 1'b0;
            alu_cont  = 3'b000;
            halted    = 1'b0;
        end
    end

    assign fault = fault_q;
    assign state = state_q;

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Multi-cycle control FSM for the accumulator CPU datapath: PC, IR, ACC, ALU and a single shared instruction/data memory port.
- Sequences fetch, decode, memory read, execute and memory write for each instruction; drives every datapath enable and mux select.
- Waits on a ready/request memory handshake and stalls for as long as memory takes.
- Applies external halt requests only at instruction boundaries; includes a memory-timeout watchdog.

Parameters:
- MEM_TIMEOUT, 15: max cycles a memory request may wait for mem_ready before fault; range 1..255.
- CNT_W, 8: wait-counter width; must satisfy 2^CNT_W > MEM_TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- opr  in  4  opcode field from IR; stable from DECODE onward.
- zero  in  1  ACC==0 flag.
- mem_ready  in  1  memory completes the current request this cycle.
- halt_req  in  1  external halt request, level.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- addr_src  out  1  memory address mux: 0=PC, 1=IR address field.
- ir_write  out  1  load IR from memory data.
- pc_write  out  1  load PC.
- pc_src  out  1  PC mux: 0=PC+1, 1=IR address field.
- acc_write  out  1  load ACC.
- acc_src  out  1  ACC mux: 0=ALU result, 1=memory data.
- alu_cont  out  3  ALU op: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 NOT.
- halted  out  1  FSM is in HALTED.
- fault  out  1  sticky memory-timeout fault.
- state  out  3  current state code, for debug.

Behaviour:
Interface:
- One clock; reset is asynchronous and active-high; ports named clk and rst.
- rst forces state=FETCH, wait counter=0, fault=0, halt cause cleared, all outputs 0, at any time including mid-handshake.

State encoding and outputs:
- States: FETCH=0, DECODE=1, MEMRD=2, EXEC=3, MEMWR=4, HALTED=5.
- Outputs are Moore-style, decoded from the state and the opcode latched in DECODE.
- Any output not listed for a state is 0.

FETCH:
- Outputs: mem_read=1, addr_src=0.
- On mem_ready: ir_write=1, pc_write=1, pc_src=0, both in that same cycle, then go to DECODE.

DECODE (1 cycle):
- Latch opr into an internal register.
- ADD(0000), SUB(0001), AND(0010), OR(0011), LDA(1000) -> MEMRD.
- NOT(0100) -> EXEC.
- STA(1001) -> MEMWR.
- JMP(0110): pc_write=1, pc_src=1, -> FETCH.
- JZ(0111): pc_write=zero, pc_src=1, -> FETCH.
- HLT(1111) -> HALTED, cause=HLT.
- Any other opcode: NOP, -> FETCH.

MEMRD:
- Outputs: mem_read=1, addr_src=1.
- On mem_ready: LDA does acc_write=1, acc_src=1, -> FETCH. ALU opcodes go to EXEC; the memory operand is registered in the datapath.

EXEC (1 cycle):
- Outputs: acc_write=1, acc_src=0, alu_cont per the latched opcode. -> FETCH.

MEMWR:
- Outputs: mem_write=1, addr_src=1.
- On mem_ready -> FETCH.

Handshake and watchdog:
- A request stays asserted until mem_ready is sampled high on a rising edge.
- mem_ready is ignored in states that issue no request.
- The wait counter clears on entry to each request state and increments every cycle mem_ready is low.
- When the counter reaches MEM_TIMEOUT with mem_ready still low: fault=1, go to HALTED (cause=FAULT).
- If mem_ready and the timeout coincide, mem_ready wins.

Halt handling:
- halt_req is sampled only on the transition into FETCH, i.e. at instruction completion. If high then, go to HALTED (cause=REQ) instead of FETCH.
- An instruction in progress always completes.
- HALTED with cause=REQ: return to FETCH the cycle after halt_req is seen low.
- HALTED with cause=HLT or FAULT: sticky until rst.
- halted=1 exactly while in HALTED.

Optional Feature:
- Macro: SEQ_ILLEGAL_TRAP_EN.
- Defined: an undefined opcode in DECODE goes to HALTED with fault=1 (sticky, cause=FAULT), and PC is not further modified.
- Undefined: undefined opcodes behave as NOP, as described above.

Test Plan:
- Reset mid-MEMRD with mem_ready low -> next cycle state=0, mem_read=1, addr_src=0, fault=0, halted=0.
- ADD with mem_ready delayed 3 cycles in FETCH and 0 in MEMRD -> mem_read held 4 cycles; ir_write and pc_write pulse once; EXEC shows alu_cont=000, acc_write=1; back at FETCH after 4+1+1+1 cycles.
- JZ with zero=0, then JZ with zero=1 -> pc_write=0, then pc_write=1 with pc_src=1, each in DECODE; no memory request issued.
- halt_req raised during a STA's MEMWR -> mem_write completes on mem_ready, then HALTED, halted=1. Drop halt_req -> FETCH one cycle later.
- mem_ready held low in FETCH with MEM_TIMEOUT=15 -> after 15 wait cycles fault=1, halted=1. Stays halted with halt_req=0 until rst.
- Opcode 0101 -> without SEQ_ILLEGAL_TRAP_EN: DECODE then FETCH, no enables. With it: HALTED, fault=1.
